intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NUM_INTR, default 4: interrupt channel count, legal range 1..16.
REQ-002 SHALL have parameter STRETCH, default 8: number of cycles bus_intr_o stays high per trigger, legal range 1..255.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock
- reset_i  in  1  synchronous active-high reset
- intr_signal_i  in  NUM_INTR  source requests (Copper, video, timer)
- intr_level_i  in  NUM_INTR  per-channel mode: 1 = level, 0 = rising edge
- intr_mask_i  in  NUM_INTR  per-channel enable
- intr_set_i  in  NUM_INTR  CPU software-set strobe
- intr_clear_i  in  NUM_INTR  CPU clear strobe
- intr_status_o  out  NUM_INTR  latched pending status
- intr_pending_o  out  1  any masked pending
- intr_vector_o  out  max(1,$clog2(NUM_INTR))  lowest masked pending index
- bus_intr_o  out  1  CPU interrupt line

Function
REQ-005 SHALL register intr_signal_i each cycle into sig_q, one bit per channel.
REQ-006 SHALL compute a per-channel event as follows:
- level channel: event = intr_signal_i
- edge channel: event = intr_signal_i & ~sig_q
REQ-007 SHALL compute status_next = (status & ~intr_clear_i) | event | intr_set_i.
REQ-008 SHALL let a set or event win over a clear on the same bit in the same cycle, so no interrupt is lost.
REQ-009 SHALL re-set a level channel every cycle while its source is high, so a clear has no lasting effect until the source drops.
REQ-010 SHALL latch status for masked channels exactly as for unmasked channels; the mask gates only outputs and triggering.
REQ-011 SHALL register mask_q <= intr_mask_i each cycle.
REQ-012 SHALL compute trigger = |(status_next & intr_mask_i & ~(status & mask_q)); this covers both a newly pending bit and unmasking of an already-pending bit.
REQ-013 SHALL implement the pulse state machine with states IDLE and PULSE and a down-counter of width $clog2(STRETCH+1):
- IDLE to PULSE on trigger; counter loads STRETCH.
- In PULSE, trigger reloads the counter to STRETCH (retrigger extends the pulse).
- In PULSE without trigger, the counter decrements.
- PULSE to IDLE when the counter equals 1 and there is no trigger.
REQ-014 SHALL drive bus_intr_o as a register that is high exactly while in PULSE.
REQ-015 SHALL raise bus_intr_o the cycle after the event or set input is sampled (1-cycle latency), and hold it for exactly STRETCH cycles after the last trigger.
REQ-016 SHALL drive intr_status_o directly from the status register.
REQ-017 SHALL compute intr_pending_o = |(status & intr_mask_i) combinationally.
REQ-018 SHALL drive intr_vector_o with the lowest index i where status[i] & intr_mask_i[i] is set, or 0 when none is set.
REQ-019 SHALL use a counter that never wraps: no decrement below 1 in PULSE, and no decrement in IDLE.

Reset
REQ-020 SHALL, while reset_i is high, clear status, sig_q, mask_q and the counter, force the state to IDLE, and drive bus_intr_o to 0.
REQ-021 SHALL make reset asserted mid-pulse drop bus_intr_o on the next edge; a pending trigger in that cycle is discarded.
REQ-022 SHALL treat an edge-mode source that is high in the first cycle after reset as a rising edge, because sig_q resets to 0.

Verification
REQ-023 Edge trigger: NUM_INTR=4, STRETCH=8, mask=4'b0001, edge mode, signal[0] goes 0->1 at cycle T -> status[0]=1 at T+1; bus_intr_o high T+1..T+8; vector=0.
REQ-024 Simultaneous set/clear: status[2]=1, clear[2] and signal rising edge [2] in the same cycle -> status[2] stays 1 and bus_intr_o does not retrigger.
REQ-025 Masked then unmasked: signal[3] edge with mask[3]=0 -> status[3]=1, no pulse, pending=0; then raise mask[3] -> pulse of STRETCH cycles, vector=3.
REQ-026 Retrigger: second trigger at pulse cycle 5 with STRETCH=8 -> bus_intr_o remains high for 8 cycles after the second trigger, 13 cycles in total.
REQ-027 Level channel: level[1]=1, signal[1] held high, clear[1] pulsed -> status[1] re-asserts the next cycle; no new pulse is produced.
REQ-028 Reset mid-pulse: reset_i asserted at pulse cycle 3 -> status=0 and bus_intr_o=0 the next cycle; with edge mode and signal held high, release of reset produces a new pulse one cycle later.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt controller with per-channel edge/level capture, sticky status,
// per-channel masking and a stretched CPU interrupt pulse.
//
// Every source is captured into a sticky status bit whether or not its channel
// is masked. The mask only affects the summary outputs and pulse triggering. A
// trigger occurs when a masked-in bit becomes pending. Unmasking a bit that is
// already pending also counts as a trigger. Each trigger starts or extends a
// pulse on bus_intr_o that lasts STRETCH cycles after the last trigger.
//
// Ports:
//   clk            clock
//   reset_i        synchronous active-high reset
//   intr_signal_i  source requests, one per channel
//   intr_level_i   per-channel mode: 1 = level, 0 = rising edge
//   intr_mask_i    per-channel enable
//   intr_set_i     software-set strobe
//   intr_clear_i   clear strobe
//   intr_status_o  latched pending status
//   intr_pending_o any masked-in channel pending
//   intr_vector_o  lowest masked-in pending index, 0 when none
//   bus_intr_o     stretched CPU interrupt line (registered)

module intr_ctrl #(
  parameter int unsigned NUM_INTR = 4,
  parameter int unsigned STRETCH  = 8
) (
  input  logic                                        clk,
  input  logic                                        reset_i,
  input  logic [NUM_INTR-1:0]                         intr_signal_i,
  input  logic [NUM_INTR-1:0]                         intr_level_i,
  input  logic [NUM_INTR-1:0]                         intr_mask_i,
  input  logic [NUM_INTR-1:0]                         intr_set_i,
  input  logic [NUM_INTR-1:0]                         intr_clear_i,
  output logic [NUM_INTR-1:0]                         intr_status_o,
  output logic                                        intr_pending_o,
  output logic [((NUM_INTR > 1) ? $clog2(NUM_INTR) : 1)-1:0] intr_vector_o,
  output logic                                        bus_intr_o
);

  localparam int unsigned VW = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1;
  localparam int unsigned CW = $clog2(STRETCH + 1);

  localparam logic [CW-1:0] StretchCnt = CW'(STRETCH);
  localparam logic [CW-1:0] CntOne     = CW'(1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StPulse = 1'b1;

  // State
  logic [NUM_INTR-1:0] sig_q;
  logic [NUM_INTR-1:0] mask_q;
  logic [NUM_INTR-1:0] status_q, status_d;
  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                bus_q, bus_d;

  // Combinational
  logic [NUM_INTR-1:0] intr_event;
  logic [NUM_INTR-1:0] active;
  logic                trigger;

  // Edge channels see a one-cycle event on a 0->1 transition. Level channels
  // see an event every cycle the source is high. A level channel therefore
  // re-sets its status bit right after a clear while its source stays high.
  assign intr_event = (intr_level_i & intr_signal_i) |
                      (~intr_level_i & intr_signal_i & ~sig_q);

  // Clear is applied first, so a set or event in the same cycle wins.
  assign status_d = (status_q & ~intr_clear_i) | intr_event | intr_set_i;

  // A bit triggers when it is enabled and pending next cycle but was not
  // enabled-and-pending this cycle. This catches new events and unmask-while-pending.
  assign trigger = |(status_d & intr_mask_i & ~(status_q & mask_q));

  // Pulse FSM. The counter reloads on every trigger and stops at 1, where the
  // FSM returns to idle. It never wraps, and it holds its value while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StPulse;
          cnt_d   = StretchCnt;
        end
      end
      StPulse: begin
        if (trigger) begin
          cnt_d = StretchCnt;
        end else if (cnt_q == CntOne) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The registered line mirrors the next state, so it is high exactly while in PULSE.
  assign bus_d = (state_d == StPulse);

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sig_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      bus_q    <= 1'b0;
    end else begin
      sig_q    <= intr_signal_i;
      mask_q   <= intr_mask_i;
      status_q <= status_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
    end
  end

  // Outputs
  assign active         = status_q & intr_mask_i;
  assign intr_status_o  = status_q;
  assign intr_pending_o = |active;
  assign bus_intr_o     = bus_q;

  // Priority encoder. The loop scans from the top, so the lowest set index wins.
  always_comb begin
    intr_vector_o = '0;
    for (int i = int'(NUM_INTR) - 1; i >= 0; i--) begin
      if (active[i]) begin
        intr_vector_o = VW'(i);
      end
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned S = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sig, lvl, mask, set, clr;
  logic [N-1:0] status;
  logic         pending;
  logic [1:0]   vector;
  logic         bus;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  intr_ctrl #(
    .NUM_INTR (N),
    .STRETCH  (S)
  ) dut (
    .clk            (clk),
    .reset_i        (reset),
    .intr_signal_i  (sig),
    .intr_level_i   (lvl),
    .intr_mask_i    (mask),
    .intr_set_i     (set),
    .intr_clear_i   (clr),
    .intr_status_o  (status),
    .intr_pending_o (pending),
    .intr_vector_o  (vector),
    .bus_intr_o     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: sticky pending bits, last-seen source and mask, and the
  // number of cycles the CPU line must still stay high.
  logic [N-1:0] m_status, m_prev_sig, m_prev_mask, m_nxt;
  int           m_remain;
  bit           m_trig, m_ev;

  always @(posedge clk) begin
    if (reset) begin
      m_status    <= '0;
      m_prev_sig  <= '0;
      m_prev_mask <= '0;
      m_remain    <= 0;
    end else begin
      m_trig = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        m_ev     = lvl[i] ? sig[i] : (sig[i] && !m_prev_sig[i]);
        m_nxt[i] = (m_status[i] && !clr[i]) || m_ev || set[i];
        if (m_nxt[i] && mask[i] && !(m_status[i] && m_prev_mask[i])) m_trig = 1'b1;
      end
      m_status    <= m_nxt;
      m_prev_sig  <= sig;
      m_prev_mask <= mask;
      if (m_trig) m_remain <= int'(S);
      else if (m_remain > 0) m_remain <= m_remain - 1;
    end
  end

  function automatic logic [31:0] exp_vector(input logic [N-1:0] st, input logic [N-1:0] mk);
    for (int i = 0; i < int'(N); i++) if (st[i] && mk[i]) return 32'(i);
    return 32'd0;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_status", 32'(status), 32'(m_status));
      check("cyc_bus", 32'(bus), 32'(m_remain > 0));
      check("cyc_pending", 32'(pending), 32'(|(m_status & mask)));
      check("cyc_vector", 32'(vector), exp_vector(m_status, mask));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    reset = 1'b1;
    sig = '0; lvl = '0; mask = '0; set = '0; clr = '0;
    step(2);
    chk_en = 1'b1;
    sample();
    check("rst_status", 32'(status), 32'd0);
    check("rst_bus", 32'(bus), 32'd0);
    step(1);
    reset = 1'b0;

    // Edge trigger on channel 0
    mask = 4'b0001;
    step(1);
    sig = 4'b0001;
    sample();
    check("edge_pre_bus", 32'(bus), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      sample();
      check("edge_bus_high", 32'(bus), 32'd1);
      if (k == 1) begin
        check("edge_status0", 32'(status[0]), 32'd1);
        check("edge_vector", 32'(vector), 32'd0);
      end
    end
    step(1);
    sample();
    check("edge_bus_end", 32'(bus), 32'd0);
    step(1);
    sig = '0; clr = 4'b0001;
    step(1);
    clr = '0; mask = '0;

    // Simultaneous clear and rising edge on an already-pending bit
    mask = 4'b0100; set = 4'b0100;
    step(1);
    set = '0;
    step(10);
    clr = 4'b0100; sig = 4'b0100;
    step(1);
    clr = '0;
    sample();
    check("setclr_status2", 32'(status[2]), 32'd1);
    check("setclr_no_retrigger", 32'(bus), 32'd0);
    step(1);
    sig = '0; clr = 4'b0100;
    step(1);
    clr = '0; mask = '0;

    // Masked capture, then unmask
    sig = 4'b1000;
    step(1);
    sample();
    check("masked_status3", 32'(status[3]), 32'd1);
    check("masked_bus", 32'(bus), 32'd0);
    check("masked_pending", 32'(pending), 32'd0);
    step(1);
    mask = 4'b1000;
    sample();
    check("unmask_pending", 32'(pending), 32'd1);
    check("unmask_vector", 32'(vector), 32'd3);
    hi = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      sample();
      if (bus) hi++;
      if (k == 1) check("unmask_bus_first", 32'(bus), 32'd1);
    end
    check("unmask_pulse_len", 32'(hi), 32'(S));
    step(1);
    sig = '0; clr = 4'b1000; mask = '0;
    step(1);
    clr = '0;

    // Retrigger at pulse cycle 5
    mask = 4'b0011;
    step(1);
    sig = 4'b0001;
    hi = 0;
    for (int c = 1; c <= 16; c++) begin
      step(1);
      if (c == 5) sig = 4'b0011;
      sample();
      if (bus) hi++;
      if (c == 13) check("retrig_bus_c13", 32'(bus), 32'd1);
      if (c == 14) check("retrig_bus_c14", 32'(bus), 32'd0);
    end
    check("retrig_pulse_len", 32'(hi), 32'd13);
    step(1);
    sig = '0; clr = 4'b0011; mask = '0;
    step(1);
    clr = '0;

    // Level channel cleared while its source stays high
    lvl = 4'b0010; mask = 4'b0010; sig = 4'b0010;
    step(12);
    clr = 4'b0010;
    step(1);
    clr = '0;
    sample();
    check("level_reassert", 32'(status[1]), 32'd1);
    check("level_no_pulse", 32'(bus), 32'd0);
    step(1);
    sig = '0;
    step(1);
    clr = 4'b0010;
    step(1);
    clr = '0; lvl = '0; mask = '0;

    // Reset in the middle of a pulse
    mask = 4'b0001;
    step(1);
    sig = 4'b0001;
    step(3);
    reset = 1'b1;
    sample();
    check("rstmid_pre_bus", 32'(bus), 32'd1);
    step(1);
    reset = 1'b0;
    sample();
    check("rstmid_status", 32'(status), 32'd0);
    check("rstmid_bus", 32'(bus), 32'd0);
    step(1);
    sample();
    check("rstmid_repulse", 32'(bus), 32'd1);
    check("rstmid_status0", 32'(status[0]), 32'd1);
    step(1);
    sig = '0; clr = 4'b1111; mask = '0;
    step(10);
    clr = '0;

    // Randomized traffic checked every cycle by the compare process
    for (int k = 0; k < 3000; k++) begin
      step(1);
      reset = ($urandom_range(0, 99) == 0);
      sig   = sig ^ (N'($urandom) & N'($urandom));
      if ($urandom_range(0, 63) == 0) lvl = N'($urandom);
      if ($urandom_range(0, 7) == 0) mask = N'($urandom);
      set = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
      clr = N'($urandom) & N'($urandom);
    end
    step(2);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
